// File: rtl/dac_spi_xy_if.sv
// rtl/dac_spi_xy_if.sv - valid/ready coordinate-pair handshake into the DAC driver
interface dac_spi_xy_if #(
   parameter int DAC_BITS = 12
);
   logic [DAC_BITS-1:0] x;
   logic [DAC_BITS-1:0] y;
   logic                in_valid;
   logic                in_ready;

   modport master (output x, y, in_valid, input in_ready);
   modport slave  (input x, y, in_valid, output in_ready);
endinterface

// File: rtl/dac_spi_xy.sv
// rtl/dac_spi_xy.sv - X/Y pair SPI driver for an MCP4922-class dual DAC (A = X, B = Y)
// Defining DAC_LDAC_EN adds the ldac_n port and a one-cycle latch pulse after each written pair.
module dac_spi_xy #(
   parameter int DAC_BITS       = 12,
   parameter int CLK_DIV        = 1,
   parameter int CS_HIGH        = 2,
   parameter bit GAIN           = 1'b1,
   parameter bit BUFFERED       = 1'b1,
   parameter bit SHUTDOWN       = 1'b1,
   parameter bit SKIP_UNCHANGED = 1'b1
) (
   input  logic        clk,
   input  logic        reset_n,
   dac_spi_xy_if.slave bus,
   output logic        cs_n,
   output logic        sclk,
   output logic        sdi,
   output logic        busy
`ifdef DAC_LDAC_EN
   ,
   output logic        ldac_n
`endif
);
   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int GAP_W = (CS_HIGH > 1) ? $clog2(CS_HIGH) : 1;
   localparam int SHIFT = 12 - DAC_BITS;

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_FRAME, S_GAP, S_LDAC} state_t;

   state_t              r_state, w_state_nxt;
   logic [DAC_BITS-1:0] r_x, r_y, r_last_a, r_last_b;
   logic [DAC_BITS-1:0] w_x_nxt, w_y_nxt, w_last_a_nxt, w_last_b_nxt;
   logic                r_vld_a, r_vld_b, r_pend_b, r_ch, r_sclk, r_cs_n, r_busy;
   logic                w_vld_a_nxt, w_vld_b_nxt, w_pend_b_nxt, w_ch_nxt, w_sclk_nxt;
   logic [15:0]         r_shift, w_shift_nxt;
   logic [3:0]          r_bit, w_bit_nxt;
   logic [DIV_W-1:0]    r_div, w_div_nxt;
   logic [GAP_W-1:0]    r_gap, w_gap_nxt;
   logic                w_send_a, w_send_b, w_start, w_start_ch;
`ifdef DAC_LDAC_EN
   logic                r_ldac_n;
`endif

   function automatic logic [15:0] frame_word(input logic ch, input logic [DAC_BITS-1:0] v);
      logic [11:0] w_val;
      w_val = 12'(v) << SHIFT;
      return {ch, BUFFERED, GAIN, SHUTDOWN, w_val};
   endfunction

   assign bus.in_ready = reset_n && (r_state == S_IDLE);
   assign cs_n         = r_cs_n;
   assign sclk         = r_sclk;
   assign sdi          = r_shift[15];
   assign busy         = r_busy;
`ifdef DAC_LDAC_EN
   assign ldac_n       = r_ldac_n;
`endif

   // A channel is skipped only when it already holds exactly this value
   assign w_send_a = !SKIP_UNCHANGED || !r_vld_a || (r_x != r_last_a);
   assign w_send_b = !SKIP_UNCHANGED || !r_vld_b || (r_y != r_last_b);

   always_comb begin
      w_state_nxt  = r_state;
      w_x_nxt      = r_x;
      w_y_nxt      = r_y;
      w_last_a_nxt = r_last_a;
      w_last_b_nxt = r_last_b;
      w_vld_a_nxt  = r_vld_a;
      w_vld_b_nxt  = r_vld_b;
      w_pend_b_nxt = r_pend_b;
      w_ch_nxt     = r_ch;
      w_sclk_nxt   = r_sclk;
      w_shift_nxt  = r_shift;
      w_bit_nxt    = r_bit;
      w_div_nxt    = r_div;
      w_gap_nxt    = r_gap;
      w_start      = 1'b0;
      w_start_ch   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (bus.in_valid) begin
               w_x_nxt     = bus.x;
               w_y_nxt     = bus.y;
               w_state_nxt = S_LOAD;
            end
         end
         S_LOAD: begin
            if (w_send_a) begin
               w_start      = 1'b1;
               w_pend_b_nxt = w_send_b;
            end else if (w_send_b) begin
               w_start      = 1'b1;
               w_start_ch   = 1'b1;
               w_pend_b_nxt = 1'b0;
            end else begin
               w_state_nxt  = S_IDLE;
            end
         end
         S_FRAME: begin
            if (r_div == DIV_W'(CLK_DIV - 1)) begin
               w_div_nxt = '0;
               if (!r_sclk) begin
                  w_sclk_nxt = 1'b1;
               end else if (r_bit == 4'd15) begin
                  w_sclk_nxt  = 1'b0;
                  w_shift_nxt = '0;
                  w_gap_nxt   = '0;
                  w_state_nxt = S_GAP;
                  if (r_ch) begin
                     w_last_b_nxt = r_y;
                     w_vld_b_nxt  = 1'b1;
                  end else begin
                     w_last_a_nxt = r_x;
                     w_vld_a_nxt  = 1'b1;
                  end
               end else begin
                  // data moves only on the falling edge so it is stable at every rise
                  w_sclk_nxt  = 1'b0;
                  w_bit_nxt   = r_bit + 4'd1;
                  w_shift_nxt = {r_shift[14:0], 1'b0};
               end
            end else begin
               w_div_nxt = r_div + 1'b1;
            end
         end
         S_GAP: begin
            if (r_gap == GAP_W'(CS_HIGH - 1)) begin
               if (r_pend_b) begin
                  w_start      = 1'b1;
                  w_start_ch   = 1'b1;
                  w_pend_b_nxt = 1'b0;
               end else begin
`ifdef DAC_LDAC_EN
                  w_state_nxt = S_LDAC;
`else
                  w_state_nxt = S_IDLE;
`endif
               end
            end else begin
               w_gap_nxt = r_gap + 1'b1;
            end
         end
         S_LDAC:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
      if (w_start) begin
         w_state_nxt = S_FRAME;
         w_ch_nxt    = w_start_ch;
         w_shift_nxt = frame_word(w_start_ch, w_start_ch ? r_y : r_x);
         w_bit_nxt   = '0;
         w_div_nxt   = '0;
         w_sclk_nxt  = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state  <= S_IDLE;
         r_x      <= '0;
         r_y      <= '0;
         r_last_a <= '0;
         r_last_b <= '0;
         r_vld_a  <= 1'b0;
         r_vld_b  <= 1'b0;
         r_pend_b <= 1'b0;
         r_ch     <= 1'b0;
         r_sclk   <= 1'b0;
         r_shift  <= '0;
         r_bit    <= '0;
         r_div    <= '0;
         r_gap    <= '0;
         r_cs_n   <= 1'b1;
         r_busy   <= 1'b0;
`ifdef DAC_LDAC_EN
         r_ldac_n <= 1'b1;
`endif
      end else begin
         r_state  <= w_state_nxt;
         r_x      <= w_x_nxt;
         r_y      <= w_y_nxt;
         r_last_a <= w_last_a_nxt;
         r_last_b <= w_last_b_nxt;
         r_vld_a  <= w_vld_a_nxt;
         r_vld_b  <= w_vld_b_nxt;
         r_pend_b <= w_pend_b_nxt;
         r_ch     <= w_ch_nxt;
         r_sclk   <= w_sclk_nxt;
         r_shift  <= w_shift_nxt;
         r_bit    <= w_bit_nxt;
         r_div    <= w_div_nxt;
         r_gap    <= w_gap_nxt;
         r_cs_n   <= (w_state_nxt != S_FRAME);
         r_busy   <= (w_state_nxt != S_IDLE);
`ifdef DAC_LDAC_EN
         r_ldac_n <= (w_state_nxt != S_LDAC);
`endif
      end
   end
endmodule

// File: tb/tb_dac_spi_xy.sv
// tb/tb_dac_spi_xy.sv - directed bench for dac_spi_xy (defaults, slow SCLK, 8-bit DAC); honours DAC_LDAC_EN
module tb_dac_spi_xy;
   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

`ifdef DAC_LDAC_EN
   localparam int LD = 1;
`else
   localparam int LD = 0;
`endif

   int n_run = 0;
   int n_fail = 0;

   logic [11:0] tx [3];
   logic [11:0] ty [3];
   logic        tv [3];
   wire         trdy [3];
   wire         tcs [3];
   wire         tsclk [3];
   wire         tsdi [3];
   wire         tbusy [3];
`ifdef DAC_LDAC_EN
   wire         tldac [3];
`endif

   dac_spi_xy_if #(.DAC_BITS(12)) if0 ();
   dac_spi_xy_if #(.DAC_BITS(12)) if1 ();
   dac_spi_xy_if #(.DAC_BITS(8))  if2 ();

   assign if0.x = tx[0];      assign if0.y = ty[0];      assign if0.in_valid = tv[0];
   assign if1.x = tx[1];      assign if1.y = ty[1];      assign if1.in_valid = tv[1];
   assign if2.x = tx[2][7:0]; assign if2.y = ty[2][7:0]; assign if2.in_valid = tv[2];
   assign trdy[0] = if0.in_ready;
   assign trdy[1] = if1.in_ready;
   assign trdy[2] = if2.in_ready;

   dac_spi_xy u0 (
      .clk(clk), .reset_n(reset_n), .bus(if0),
      .cs_n(tcs[0]), .sclk(tsclk[0]), .sdi(tsdi[0]), .busy(tbusy[0])
`ifdef DAC_LDAC_EN
      , .ldac_n(tldac[0])
`endif
   );

   dac_spi_xy #(.CLK_DIV(3), .CS_HIGH(4)) u1 (
      .clk(clk), .reset_n(reset_n), .bus(if1),
      .cs_n(tcs[1]), .sclk(tsclk[1]), .sdi(tsdi[1]), .busy(tbusy[1])
`ifdef DAC_LDAC_EN
      , .ldac_n(tldac[1])
`endif
   );

   dac_spi_xy #(.DAC_BITS(8)) u2 (
      .clk(clk), .reset_n(reset_n), .bus(if2),
      .cs_n(tcs[2]), .sclk(tsclk[2]), .sdi(tsdi[2]), .busy(tbusy[2])
`ifdef DAC_LDAC_EN
      , .ldac_n(tldac[2])
`endif
   );

   // per-pair observations, cycle k = interval after the k-th clk edge following the handshake
   int          n_fr, rdy_k, ldac_k, ldac_cnt, pin_bad, run_min, run_max;
   logic        busy_k0;
   logic [15:0] fw [4];
   int          fs [4];
   int          fe [4];

   task automatic handshake(input int d, input logic [11:0] xv, input logic [11:0] yv);
      @(negedge clk);
      n_run++; if (trdy[d] !== 1'b1) begin n_fail++; $display("FAIL hs_ready dut%0d: in_ready=%b required 1", d, trdy[d]); end
      tx[d] = xv; ty[d] = yv; tv[d] = 1'b1;
      @(negedge clk);
      tv[d] = 1'b0; tx[d] = ~xv; ty[d] = ~yv;
   endtask

   task automatic collect(input int d);
      logic        pcs, psclk, psdi, cs, sc, sd;
      logic [15:0] sh;
      int          run;
      pcs = 1'b1; psclk = 1'b0; psdi = 1'b0; sh = '0; run = 0;
      n_fr = 0; rdy_k = -1; ldac_k = -1; ldac_cnt = 0; pin_bad = 0;
      run_min = 1000; run_max = 0; busy_k0 = 1'b0;
      for (int k = 0; k < 1000; k++) begin
         cs = tcs[d]; sc = tsclk[d]; sd = tsdi[d];
         if (k == 0) busy_k0 = tbusy[d];
         if (cs && (sc || sd)) pin_bad++;
         if (!cs && pcs) begin
            if (n_fr < 4) fs[n_fr] = k;
            sh = '0; run = 1;
         end else if (!cs) begin
            if (sd != psdi && !(!sc && psclk)) pin_bad++;
            if (sc == psclk) run++;
            else begin
               if (run < run_min) run_min = run;
               if (run > run_max) run_max = run;
               run = 1;
            end
         end
         if (!cs && sc && !psclk) sh = {sh[14:0], sd};
         if (cs && !pcs) begin
            if (run < run_min) run_min = run;
            if (run > run_max) run_max = run;
            if (n_fr < 4) begin fe[n_fr] = k - 1; fw[n_fr] = sh; end
            n_fr++;
         end
`ifdef DAC_LDAC_EN
         if (tldac[d] === 1'b0) begin ldac_cnt++; ldac_k = k; end
`endif
         if (trdy[d] === 1'b1) begin rdy_k = k; break; end
         pcs = cs; psclk = sc; psdi = sd;
         @(negedge clk);
      end
      if (rdy_k < 0) begin n_run++; n_fail++; $display("FAIL timeout dut%0d: in_ready never returned", d); end
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (3) @(negedge clk);
      n_run++; if (tcs[0] !== 1'b1)   begin n_fail++; $display("FAIL rst_cs_n: got %b required 1", tcs[0]); end
      n_run++; if (tsclk[0] !== 1'b0) begin n_fail++; $display("FAIL rst_sclk: got %b required 0", tsclk[0]); end
      n_run++; if (tsdi[0] !== 1'b0)  begin n_fail++; $display("FAIL rst_sdi: got %b required 0", tsdi[0]); end
      n_run++; if (tbusy[0] !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b required 0", tbusy[0]); end
      n_run++; if (trdy[0] !== 1'b0)  begin n_fail++; $display("FAIL rst_ready: got %b required 0", trdy[0]); end
`ifdef DAC_LDAC_EN
      n_run++; if (tldac[0] !== 1'b1) begin n_fail++; $display("FAIL rst_ldac: got %b required 1", tldac[0]); end
`endif
      reset_n = 1'b1;
      @(negedge clk);
      n_run++; if (trdy[0] !== 1'b1)  begin n_fail++; $display("FAIL rst_release_ready: got %b required 1", trdy[0]); end
   endtask

   task automatic test_two_frames();
      handshake(0, 12'hABC, 12'h123);
      collect(0);
      n_run++; if (n_fr !== 2)          begin n_fail++; $display("FAIL two_nfr: got %0d required 2", n_fr); end
      n_run++; if (fw[0] !== 16'h7ABC)  begin n_fail++; $display("FAIL two_word_a: got %h required 7abc", fw[0]); end
      n_run++; if (fw[1] !== 16'hF123)  begin n_fail++; $display("FAIL two_word_b: got %h required f123", fw[1]); end
      n_run++; if (fs[0] !== 1 || fe[0] !== 32)  begin n_fail++; $display("FAIL two_cs_a: got %0d-%0d required 1-32", fs[0], fe[0]); end
      n_run++; if (fs[1] !== 35 || fe[1] !== 66) begin n_fail++; $display("FAIL two_cs_b: got %0d-%0d required 35-66", fs[1], fe[1]); end
      n_run++; if (rdy_k !== 69 + LD)   begin n_fail++; $display("FAIL two_ready: got %0d required %0d", rdy_k, 69 + LD); end
      n_run++; if (busy_k0 !== 1'b1)    begin n_fail++; $display("FAIL two_busy: got %b required 1", busy_k0); end
      n_run++; if (pin_bad !== 0)       begin n_fail++; $display("FAIL two_pins: got %0d bad samples required 0", pin_bad); end
      n_run++; if (run_min !== 1 || run_max !== 1) begin n_fail++; $display("FAIL two_sclk_level: got %0d..%0d required 1..1", run_min, run_max); end
`ifdef DAC_LDAC_EN
      n_run++; if (ldac_cnt !== 1 || ldac_k !== 69) begin n_fail++; $display("FAIL two_ldac: got %0d pulses at %0d required 1 at 69", ldac_cnt, ldac_k); end
`endif
   endtask

   task automatic test_skip();
      handshake(0, 12'hABC, 12'h456);
      collect(0);
      n_run++; if (n_fr !== 1)          begin n_fail++; $display("FAIL skip_nfr: got %0d required 1", n_fr); end
      n_run++; if (fw[0] !== 16'hF456)  begin n_fail++; $display("FAIL skip_word_b: got %h required f456", fw[0]); end
      n_run++; if (fs[0] !== 1 || fe[0] !== 32) begin n_fail++; $display("FAIL skip_cs_b: got %0d-%0d required 1-32", fs[0], fe[0]); end
      n_run++; if (rdy_k !== 35 + LD)   begin n_fail++; $display("FAIL skip_ready: got %0d required %0d", rdy_k, 35 + LD); end
      handshake(0, 12'hABC, 12'h456);
      collect(0);
      n_run++; if (n_fr !== 0)          begin n_fail++; $display("FAIL skipall_nfr: got %0d required 0", n_fr); end
      n_run++; if (rdy_k !== 1)         begin n_fail++; $display("FAIL skipall_ready: got %0d required 1", rdy_k); end
      n_run++; if (busy_k0 !== 1'b1)    begin n_fail++; $display("FAIL skipall_busy: got %b required 1", busy_k0); end
`ifdef DAC_LDAC_EN
      n_run++; if (ldac_cnt !== 0)      begin n_fail++; $display("FAIL skipall_ldac: got %0d pulses required 0", ldac_cnt); end
`endif
   endtask

   task automatic test_clk_div();
      handshake(1, 12'hABC, 12'h123);
      collect(1);
      n_run++; if (fw[0] !== 16'h7ABC || fw[1] !== 16'hF123) begin n_fail++; $display("FAIL div_words: got %h %h required 7abc f123", fw[0], fw[1]); end
      n_run++; if (fs[0] !== 1 || fe[0] - fs[0] + 1 !== 96)  begin n_fail++; $display("FAIL div_frame: got start %0d len %0d required 1 96", fs[0], fe[0] - fs[0] + 1); end
      n_run++; if (fs[1] - fe[0] - 1 !== 4) begin n_fail++; $display("FAIL div_gap: got %0d required 4", fs[1] - fe[0] - 1); end
      n_run++; if (run_min !== 3 || run_max !== 3) begin n_fail++; $display("FAIL div_sclk_level: got %0d..%0d required 3..3", run_min, run_max); end
      n_run++; if (pin_bad !== 0)       begin n_fail++; $display("FAIL div_pins: got %0d bad samples required 0", pin_bad); end
      n_run++; if (rdy_k !== 201 + LD)  begin n_fail++; $display("FAIL div_ready: got %0d required %0d", rdy_k, 201 + LD); end
   endtask

   task automatic test_dac8();
      handshake(2, 12'h0A5, 12'h03C);
      collect(2);
      n_run++; if (n_fr !== 2)          begin n_fail++; $display("FAIL dac8_nfr: got %0d required 2", n_fr); end
      n_run++; if (fw[0] !== 16'h7A50)  begin n_fail++; $display("FAIL dac8_word_a: got %h required 7a50", fw[0]); end
      n_run++; if (fw[1] !== 16'hF3C0)  begin n_fail++; $display("FAIL dac8_word_b: got %h required f3c0", fw[1]); end
   endtask

   task automatic test_reset_mid();
      handshake(0, 12'h321, 12'h654);
      collect(0);
      n_run++; if (n_fr !== 2)          begin n_fail++; $display("FAIL mid_first_nfr: got %0d required 2", n_fr); end
      handshake(0, 12'h320, 12'h654);
      repeat (17) @(negedge clk);
      n_run++; if (tcs[0] !== 1'b0)     begin n_fail++; $display("FAIL mid_in_frame: cs_n=%b required 0", tcs[0]); end
      reset_n = 1'b0;
      @(negedge clk);
      n_run++; if (tcs[0] !== 1'b1)     begin n_fail++; $display("FAIL mid_cs_n: got %b required 1", tcs[0]); end
      n_run++; if (tsclk[0] !== 1'b0)   begin n_fail++; $display("FAIL mid_sclk: got %b required 0", tsclk[0]); end
      n_run++; if (trdy[0] !== 1'b0)    begin n_fail++; $display("FAIL mid_ready: got %b required 0", trdy[0]); end
      n_run++; if (tbusy[0] !== 1'b0)   begin n_fail++; $display("FAIL mid_busy: got %b required 0", tbusy[0]); end
      reset_n = 1'b1;
      @(negedge clk);
      handshake(0, 12'h321, 12'h654);
      collect(0);
      n_run++; if (n_fr !== 2)          begin n_fail++; $display("FAIL mid_resend_nfr: got %0d required 2", n_fr); end
      n_run++; if (fw[0] !== 16'h7321 || fw[1] !== 16'hF654) begin n_fail++; $display("FAIL mid_resend_words: got %h %h required 7321 f654", fw[0], fw[1]); end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 3; i++) begin
         tx[i] = '0; ty[i] = '0; tv[i] = 1'b0;
      end
      test_reset();
      test_two_frames();
      test_skip();
      test_clk_div();
      test_dac8();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end
endmodule
